// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared data memory.
// Grant locking is compiled in only when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int READ_LAT = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p0_req,
  input  logic       p1_req,
  input  logic [7:0] p0_cmd,
  input  logic [7:0] p1_cmd,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p0_wdata,
  input  logic [7:0] p1_wdata,
  input  logic       p0_lock,
  input  logic       p1_lock,
  output logic       p0_gnt,
  output logic       p1_gnt,
  output logic       p0_done,
  output logic       p1_done,
  output logic [7:0] p0_rdata,
  output logic [7:0] p1_rdata,
  output logic [7:0] mem_cmd,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy
);
  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_reg, state_next;

  logic            owner_reg;
  logic            ptr_reg;
  logic            ok_reg;
  logic            rd_reg;
  logic [2:0]      lat_cnt_reg;
  logic [7:0]      mem_cmd_reg;
  logic [7:0]      mem_addr_reg;
  logic [7:0]      mem_wdata_reg;
  logic [1:0][7:0] rdata_reg;

  logic [1:0]      req;
  logic [1:0][7:0] cmd_in;
  logic [1:0][7:0] addr_in;
  logic [1:0][7:0] wdata_in;
  logic            grant_valid;
  logic            grant_port;
  logic            lock_hold;
  logic [7:0]      sel_cmd;
  logic            sel_ok;

  assign req      = {p1_req, p0_req};
  assign cmd_in   = {p1_cmd, p0_cmd};
  assign addr_in  = {p1_addr, p0_addr};
  assign wdata_in = {p1_wdata, p0_wdata};
  assign sel_cmd  = cmd_in[grant_port];
  assign sel_ok   = (sel_cmd == CMD_READ) || (sel_cmd == CMD_WRITE);

`ifdef DMEM_ARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);
  logic           lock_active_reg;
  logic [LCW-1:0] lock_cnt_reg;
  logic           owner_lock;

  assign owner_lock = owner_reg ? p1_lock : p0_lock;
  assign lock_hold  = lock_active_reg && req[owner_reg];

  // The pointer already favours the other port on every release path.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active_reg <= 1'b0;
      lock_cnt_reg    <= '0;
    end else if (state_reg == DONE) begin
      if (owner_lock && (int'(lock_cnt_reg) + 1 < LOCK_MAX)) begin
        lock_active_reg <= 1'b1;
        lock_cnt_reg    <= lock_cnt_reg + 1'b1;
      end else begin
        lock_active_reg <= 1'b0;
        lock_cnt_reg    <= '0;
      end
    end else if (state_reg == IDLE && lock_active_reg && !req[owner_reg]) begin
      lock_active_reg <= 1'b0;
      lock_cnt_reg    <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = p0_lock ^ p1_lock ^ (LOCK_MAX < 1);
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = ptr_reg;
    if (lock_hold) begin
      grant_valid = 1'b1;
      grant_port  = owner_reg;
    end else if (req[ptr_reg]) begin
      grant_valid = 1'b1;
      grant_port  = ptr_reg;
    end else if (req[~ptr_reg]) begin
      grant_valid = 1'b1;
      grant_port  = ~ptr_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = ok_reg ? WAIT : DONE;
      WAIT:    if (lat_cnt_reg == 3'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The memory bus is registered at grant so it is valid exactly in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      ptr_reg       <= 1'b0;
      ok_reg        <= 1'b0;
      rd_reg        <= 1'b0;
      lat_cnt_reg   <= 3'd0;
      mem_cmd_reg   <= CMD_IDLE;
      mem_addr_reg  <= 8'h00;
      mem_wdata_reg <= 8'h00;
      rdata_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      mem_cmd_reg <= CMD_IDLE;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            owner_reg <= grant_port;
            ok_reg    <= sel_ok;
            rd_reg    <= (sel_cmd == CMD_READ);
            if (sel_ok) begin
              mem_cmd_reg   <= sel_cmd;
              mem_addr_reg  <= addr_in[grant_port];
              mem_wdata_reg <= wdata_in[grant_port];
            end
          end
        end
        ISSUE: begin
          lat_cnt_reg <= 3'(READ_LAT);
          if (!ok_reg) rdata_reg[owner_reg] <= 8'h00;
        end
        WAIT: begin
          lat_cnt_reg <= lat_cnt_reg - 3'd1;
          if (lat_cnt_reg == 3'd1 && rd_reg) rdata_reg[owner_reg] <= mem_rdata;
        end
        DONE: ptr_reg <= ~owner_reg;
        default: ;
      endcase
    end
  end

  logic [1:0] gnt_vec;
  logic [1:0] done_vec;
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign gnt_vec[gi]  = (state_reg != IDLE) && (owner_reg == 1'(gi));
    assign done_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
  end

  assign p0_gnt    = gnt_vec[0];
  assign p1_gnt    = gnt_vec[1];
  assign p0_done   = done_vec[0];
  assign p1_done   = done_vec[1];
  assign p0_rdata  = rdata_reg[0];
  assign p1_rdata  = rdata_reg[1];
  assign mem_cmd   = mem_cmd_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps plus random rounds, checked against a
// transaction-level model (latency arithmetic, round-robin order, shadow memory).
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int RL = 3;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_RAND = 1'b0;
`else
  localparam bit LOCK_RAND = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p1_req, p0_lock, p1_lock;
  logic [7:0] p0_cmd, p1_cmd, p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_done, p1_done, busy;
  logic [7:0] p0_rdata, p1_rdata, mem_cmd, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  always #5 clk = ~clk;

  dmem_arbiter #(.READ_LAT(RL), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_cmd(p0_cmd), .p1_cmd(p1_cmd),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_lock(p0_lock), .p1_lock(p1_lock), .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_done(p0_done), .p1_done(p1_done), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_pass = 0, n_fail = 0, n_total = 0, cyc = 0;
  logic [7:0] shadow [256];
  logic [7:0] exp_rdata [2];
  bit ptr_model;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a * 8'd37) ^ 8'h5A;
  endfunction

  function automatic bit cmd_ok(input logic [7:0] c);
    return (c == 8'h01) || (c == 8'h02);
  endfunction

  function automatic int lat_of(input logic [7:0] c);
    return cmd_ok(c) ? RL + 2 : 2;
  endfunction

  // Memory responder: read data is valid only in the cycle READ_LAT after the command.
  logic [7:0] mem [256];
  bit         mem_wr [256];
  logic [7:0] pipe_data [8];
  bit         pipe_vld [8];
  int         mcyc = 0;
  always @(negedge clk) begin
    int slot;
    slot = mcyc % 8;
    mem_rdata = pipe_vld[slot] ? pipe_data[slot] : 8'($urandom);
    pipe_vld[slot] = 1'b0;
    if (mem_cmd == 8'h01) begin
      pipe_data[(mcyc + RL) % 8] = mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
      pipe_vld[(mcyc + RL) % 8]  = 1'b1;
    end else if (mem_cmd == 8'h02) begin
      mem[mem_addr]    = mem_wdata;
      mem_wr[mem_addr] = 1'b1;
    end
    mcyc++;
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic [7:0] c,
                          input logic [7:0] a, input logic [7:0] w);
    logic lk;
    lk = LOCK_RAND ? 1'($urandom) : 1'b0;
    if (p == 0) begin
      p0_req = r; p0_cmd = c; p0_addr = a; p0_wdata = w; p0_lock = lk;
    end else begin
      p1_req = r; p1_cmd = c; p1_addr = a; p1_wdata = w; p1_lock = lk;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {p1_gnt, p0_gnt}, 0);
    check({tag, "_done"}, {p1_done, p0_done}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdata0"}, p0_rdata, 8'h00);
    check({tag, "_rdata1"}, p1_rdata, 8'h00);
    check({tag, "_mem_cmd"}, mem_cmd, 8'h00);
    check({tag, "_mem_addr"}, mem_addr, 8'h00);
    check({tag, "_mem_wdata"}, mem_wdata, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    ptr_model = 1'b0;
  endtask

  // One arbitration round: one or both ports request in the same cycle.
  task automatic run_round(input bit u0, input bit u1,
                           input logic [7:0] c0, input logic [7:0] a0, input logic [7:0] w0,
                           input logic [7:0] c1, input logic [7:0] a1, input logic [7:0] w1);
    int first, second, s, s2, last;
    int d_exp [2], d_seen [2], n_done [2];
    logic [7:0] c [2], a [2], w [2];
    logic [1:0] exp_g;
    logic [7:0] exp_cmd, exp_addr, exp_wdata;
    bit both;
    c[0] = c0; a[0] = a0; w[0] = w0; c[1] = c1; a[1] = a1; w[1] = w1;
    both   = u0 && u1;
    first  = both ? int'(ptr_model) : (u0 ? 0 : 1);
    second = 1 - first;
    s      = cyc;
    d_exp[first]  = s + lat_of(c[first]);
    s2            = d_exp[first] + 1;
    d_exp[second] = both ? s2 + lat_of(c[second]) : -1;
    last          = both ? d_exp[second] : d_exp[first];
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? first : second;
      if (k == 0 || both) begin
        if (c[p] == 8'h01) exp_rdata[p] = shadow[a[p]];
        else if (c[p] == 8'h02) shadow[a[p]] = w[p];
        else exp_rdata[p] = 8'h00;
      end
    end
    ptr_model = (both ? second : first) == 0;
    set_port(0, u0, c0, a0, w0);
    set_port(1, u1, c1, a1, w1);
    d_seen[0] = -1; d_seen[1] = -1; n_done[0] = 0; n_done[1] = 0;
    while (cyc < last + 2) begin
      step();
      exp_g = 2'b00;
      if (cyc > s && cyc <= d_exp[first]) exp_g[first] = 1'b1;
      if (both && cyc > s2 && cyc <= d_exp[second]) exp_g[second] = 1'b1;
      check("gnt", {p1_gnt, p0_gnt}, exp_g);
      check("busy", busy, |exp_g);
      exp_cmd = 8'h00; exp_addr = 8'h00; exp_wdata = 8'h00;
      if (cyc == s + 1 && cmd_ok(c[first])) begin
        exp_cmd = c[first]; exp_addr = a[first]; exp_wdata = w[first];
      end
      if (both && cyc == s2 + 1 && cmd_ok(c[second])) begin
        exp_cmd = c[second]; exp_addr = a[second]; exp_wdata = w[second];
      end
      check("mem_cmd", mem_cmd, exp_cmd);
      if (exp_cmd != 8'h00) check("mem_addr", mem_addr, exp_addr);
      if (exp_cmd == 8'h02) check("mem_wdata", mem_wdata, exp_wdata);
      // Inputs change after grant; the latched transaction must be unaffected.
      if (cyc == s + 1) set_port(first, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      if (both && cyc == s2 + 1)
        set_port(second, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      if (p0_done) begin n_done[0]++; d_seen[0] = cyc; p0_req = 1'b0; end
      if (p1_done) begin n_done[1]++; d_seen[1] = cyc; p1_req = 1'b0; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if ((p == 0 && u0) || (p == 1 && u1)) begin
        check($sformatf("p%0d_done_latency", p), d_seen[p] - s, d_exp[p] - s);
        check($sformatf("p%0d_done_count", p), n_done[p], 1);
      end else begin
        check($sformatf("p%0d_no_done", p), n_done[p], 0);
      end
    end
    check("p0_rdata", p0_rdata, exp_rdata[0]);
    check("p1_rdata", p1_rdata, exp_rdata[1]);
    $display("round u0=%0d u1=%0d c0=%h a0=%h c1=%h a1=%h rdata=%h/%h", u0, u1, c0, a0, c1, a1,
             p0_rdata, p1_rdata);
  endtask

  // Both ports request continuously; pat[k] is the port expected on the k-th done.
  task automatic run_stream(input int n, input logic [7:0] pat, input bit lk0);
    int s, seen;
    int ev_port [8], ev_cyc [8];
    for (int k = 0; k < 8; k++) begin ev_port[k] = -1; ev_cyc[k] = -1; end
    p0_req = 1'b1; p0_cmd = 8'h01; p0_addr = 8'h40; p0_wdata = 8'h00; p0_lock = lk0;
    p1_req = 1'b1; p1_cmd = 8'h01; p1_addr = 8'h41; p1_wdata = 8'h00; p1_lock = 1'b0;
    s = cyc;
    seen = 0;
    for (int t = 0; t < n * (RL + 3) + 6 && seen < n; t++) begin
      step();
      if (p0_done || p1_done) begin
        ev_port[seen] = p1_done ? 1 : 0;
        ev_cyc[seen]  = cyc;
        seen++;
        if (seen == n) begin
          p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0;
        end
      end
    end
    p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("stream_port_%0d", k), ev_port[k], 32'(pat[k]));
      check($sformatf("stream_cycle_%0d", k), ev_cyc[k] - s, RL + 2 + k * (RL + 3));
      $display("stream done %0d: port %0d cycle %0d", k, ev_port[k], ev_cyc[k] - s);
    end
    repeat (2) step();
    exp_rdata[0] = shadow[8'h40];
    exp_rdata[1] = shadow[8'h41];
    ptr_model = ~pat[n-1];
    check("stream_rdata0", p0_rdata, exp_rdata[0]);
    check("stream_rdata1", p1_rdata, exp_rdata[1]);
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    p0_req = 1'b0; p0_cmd = 8'h00; p0_addr = 8'h00; p0_wdata = 8'h00; p0_lock = 1'b0;
    p1_req = 1'b0; p1_cmd = 8'h00; p1_addr = 8'h00; p1_wdata = 8'h00; p1_lock = 1'b0;
    for (int a = 0; a < 256; a++) shadow[a] = init_val(8'(a));
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    ptr_model = 1'b0;
    step();

    run_round(1'b1, 1'b0, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    run_round(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h3C);
    run_round(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h20, 8'h00);
    check("write_read_back", p1_rdata, 8'h3C);
    run_round(1'b1, 1'b0, 8'h07, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);

    do_reset();
    run_stream(4, 8'b1010, 1'b0);

    // Reset in the second WAIT cycle drops the access without a done pulse.
    p0_req = 1'b1; p0_cmd = 8'h01; p0_addr = 8'h55; p0_wdata = 8'h00;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_reset_outputs("mid_wait_reset");
    rst = 1'b0; p0_req = 1'b0;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    ptr_model = 1'b0;
    ndone = 0;
    repeat (RL + 4) begin
      step();
      if (p0_done || p1_done) ndone++;
    end
    check("mid_wait_no_done", ndone, 0);
    run_round(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h20, 8'h00);

`ifdef DMEM_ARB_LOCK_EN
    do_reset();
    run_stream(5, 8'b10000, 1'b1);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [7:0] cc [2], aa [2], ww [2];
      int mask;
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        int r;
        r = $urandom_range(0, 4);
        cc[p] = (r < 2) ? 8'h01 : (r < 4) ? 8'h02 : 8'(8'h03 + $urandom_range(0, 200));
        aa[p] = 8'($urandom_range(0, 7));
        ww[p] = 8'($urandom);
      end
      run_round(mask[0], mask[1], cc[0], aa[0], ww[0], cc[1], aa[1], ww[1]);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
